// File: rtl/mul256_op_seq_pkg.sv
// Shared widths and FSM state encoding for the mul256 operand-port sequencer.
package mul256_pkg;

  localparam int OP_W   = 260;
  localparam int PROD_W = 520;
  localparam int ADDR_W = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_CAP_B,
    ST_START,
    ST_WAIT,
    ST_WR_LO,
    ST_WR_HI,
    ST_FIN
  } state_e;

endpackage

// File: rtl/mul256_op_seq_if.sv
// Command, operand-memory and multiplier signals of the sequencer.
// master = sequencer side, slave = command source / memory / multiplier side.
interface mul256_op_seq_if;
  import mul256_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_a;
  logic [ADDR_W-1:0] cmd_b;
  logic [ADDR_W-1:0] cmd_dst;
  logic              busy;
  logic              done;
  logic              err;
  logic              op_read;
  logic [ADDR_W-1:0] op_raddr;
  logic [OP_W-1:0]   op_rdata;
  logic              op_write;
  logic [ADDR_W-1:0] op_waddr;
  logic [OP_W-1:0]   op_wdata;
  logic              op_wready;
  logic              mul_start;
  logic [OP_W-1:0]   mul_a;
  logic [OP_W-1:0]   mul_b;
  logic              mul_done;
  logic [PROD_W-1:0] mul_p;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_dst, op_rdata, op_wready, mul_done, mul_p,
    output cmd_ready, busy, done, err, op_read, op_raddr, op_write, op_waddr,
           op_wdata, mul_start, mul_a, mul_b
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_dst, op_rdata, op_wready, mul_done, mul_p,
    input  cmd_ready, busy, done, err, op_read, op_raddr, op_write, op_waddr,
           op_wdata, mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/mul256_op_seq.sv
// Reads two operands, runs the external multiplier and writes the 520-bit
// product back as two consecutive words (dst, dst+1 with 6-bit wrap).
module mul256_op_seq
  import mul256_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  mul256_op_seq_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] a_q, a_d, b_q, b_d, dst_q, dst_d;
  logic [OP_W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              cmd_ready, busy, done, err, op_read, op_write, mul_start;
  logic [ADDR_W-1:0] op_raddr, op_waddr;
  logic [OP_W-1:0]   op_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    dst_d     = dst_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    op_read   = 1'b0;
    op_raddr  = '0;
    op_write  = 1'b0;
    op_waddr  = '0;
    op_wdata  = '0;
    mul_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (bus.cmd_valid) begin
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          dst_d   = bus.cmd_dst;
          state_d = ST_RD_A;
        end
      end
      ST_RD_A: begin
        op_read  = 1'b1;
        op_raddr = a_q;
        state_d  = ST_RD_B;
      end
      // Operand A arrives while operand B is being addressed.
      ST_RD_B: begin
        op_read  = 1'b1;
        op_raddr = b_q;
        mul_a_d  = bus.op_rdata;
        state_d  = ST_CAP_B;
      end
      ST_CAP_B: begin
        mul_b_d = bus.op_rdata;
        state_d = ST_START;
      end
      ST_START: begin
        mul_start = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WAIT;
      end
      // A product arriving on the timeout cycle still wins.
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mul_done) begin
          prod_d  = bus.mul_p;
          state_d = ST_WR_LO;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_LO: begin
        op_write = 1'b1;
        op_waddr = dst_q;
        op_wdata = prod_q[OP_W-1:0];
        if (bus.op_wready) state_d = ST_WR_HI;
      end
      ST_WR_HI: begin
        op_write = 1'b1;
        op_waddr = dst_q + ADDR_W'(1);
        op_wdata = prod_q[PROD_W-1:OP_W];
        if (bus.op_wready) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.op_read   = op_read;
  assign bus.op_raddr  = op_raddr;
  assign bus.op_write  = op_write;
  assign bus.op_waddr  = op_waddr;
  assign bus.op_wdata  = op_wdata;
  assign bus.mul_start = mul_start;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;

endmodule

// File: tb/tb_mul256_op_seq.sv
// Bench for mul256_op_seq: operand memory, stallable write grant and a
// delayed multiplier around the sequencer; product writes are scoreboarded.
module tb_mul256_op_seq;
  import mul256_pkg::*;

  localparam int TO = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OP_W-1:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul256_op_seq_if bus();

  mul256_op_seq #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus-side variables
  logic              cmd_valid = 1'b0;
  logic [ADDR_W-1:0] cmd_a = '0, cmd_b = '0, cmd_dst = '0;
  logic              mul_done_pulse = 1'b0;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [OP_W-1:0]   load_data = '0;
  int                stall_cfg = 0;
  int                mul_delay = 4;

  // Model state
  logic [OP_W-1:0]   mem [64];
  logic [OP_W-1:0]   rdata_q = '0;
  logic              wready_q = 1'b0;
  int                st_cnt = 0;
  int                mcnt = 0;
  logic              mul_done_m = 1'b0;
  logic [PROD_W-1:0] mul_p_q = '0;

  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd_a     = cmd_a;
  assign bus.cmd_b     = cmd_b;
  assign bus.cmd_dst   = cmd_dst;
  assign bus.op_rdata  = rdata_q;
  assign bus.op_wready = wready_q;
  assign bus.mul_done  = mul_done_m | mul_done_pulse;
  assign bus.mul_p     = mul_p_q;

  // Memory with 1-cycle read and a write grant that lags op_write by 1+stall cycles
  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (bus.op_read) rdata_q <= mem[bus.op_raddr];
    if (bus.op_write && wready_q) mem[bus.op_waddr] <= bus.op_wdata;
    if (!bus.op_write) begin
      wready_q <= 1'b0;
      st_cnt   <= stall_cfg;
    end else if (!wready_q) begin
      if (st_cnt > 0) st_cnt <= st_cnt - 1;
      else wready_q <= 1'b1;
    end
  end

  // Multiplier: mul_done mul_delay cycles after mul_start; mul_delay 0 = never
  always @(posedge clk) begin
    mul_done_m <= 1'b0;
    if (bus.mul_start) begin
      mcnt    <= mul_delay - 1;
      mul_p_q <= PROD_W'(bus.mul_a) * PROD_W'(bus.mul_b);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_done_m <= 1'b1;
    end
  end

  // Monitor: records committed writes and event counts
  wr_t obs_q[$];
  int  n_writes = 0, n_wreq = 0, n_done = 0, n_err = 0, n_acc = 0;
  int  n_overlap = 0, n_muldone = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.op_write && bus.op_wready) begin
        obs_q.push_back('{addr: bus.op_waddr, data: bus.op_wdata});
        n_writes++;
      end
      if (bus.op_write) n_wreq++;
      if (bus.op_read && bus.op_write) n_overlap++;
      if (bus.done) n_done++;
      if (bus.err) n_err++;
      if (bus.cmd_valid && bus.cmd_ready) n_acc++;
      if (bus.mul_done) n_muldone++;
    end
  end

  wr_t exp_q[$];
  int  rd_idx = 0;
  int  checks = 0;
  int  errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [ADDR_W-1:0] addr, input logic [OP_W-1:0] data);
    load_addr = addr;
    load_data = data;
    load_en   = 1'b1;
    tick();
    load_en   = 1'b0;
  endtask

  // Drive one command; leaves cmd_valid high when hold is set.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W-1:0] dst, input bit push_exp, input bit hold);
    logic [PROD_W-1:0] p;
    int guard;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (!bus.cmd_ready) begin
      errors++;
      $display("FAIL issue_ready: cmd_ready=%0b required 1", bus.cmd_ready);
    end
    if (push_exp) begin
      p = PROD_W'(mem[a]) * PROD_W'(mem[b]);
      exp_q.push_back('{addr: dst, data: p[OP_W-1:0]});
      exp_q.push_back('{addr: dst + ADDR_W'(1), data: p[PROD_W-1:OP_W]});
    end
    cmd_a     = a;
    cmd_b     = b;
    cmd_dst   = dst;
    cmd_valid = 1'b1;
    tick();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_end(output int cyc, output int start_cyc, output bit busy_all,
                          output bit got_done, output bit got_err);
    cyc = 0; start_cyc = -1; busy_all = 1'b1; got_done = 1'b0; got_err = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cyc > 0 || i > 0) ;
      if (!bus.busy) busy_all = 1'b0;
      if (bus.mul_start && start_cyc < 0) start_cyc = cyc;
      if (bus.done) begin got_done = 1'b1; break; end
      if (bus.err) begin got_err = 1'b1; break; end
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.err, bus.op_read, bus.op_write, bus.mul_start} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: {rdy,busy,done,err,rd,wr,start}=%b required 1000000",
               {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.op_read, bus.op_write, bus.mul_start});
    end
    checks++;
    if (bus.mul_a !== '0 || bus.mul_b !== '0 || bus.op_wdata !== '0 || bus.op_waddr !== '0 || bus.op_raddr !== '0) begin
      errors++;
      $display("FAIL reset_data: mul_a/mul_b/op_wdata/addrs not all zero (waddr=%0d raddr=%0d)",
               bus.op_waddr, bus.op_raddr);
    end
  endtask

  task automatic test_basic();
    int cyc, sc, w0; bit ball, gd, ge; wr_t e, o;
    load(6'd3, OP_W'(5));
    load(6'd7, OP_W'(9));
    mul_delay = 4; stall_cfg = 0; w0 = n_writes;
    issue(6'd3, 6'd7, 6'd10, 1'b1, 1'b0);
    wait_end(cyc, sc, ball, gd, ge);
    cyc++;  // issue() already advanced one cycle past the accept edge
    checks++;
    if (!gd || cyc != 12) begin
      errors++;
      $display("FAIL basic_latency: done=%0b after %0d cycles required done=1 after 12", gd, cyc);
    end
    checks++;
    if (!ball) begin errors++; $display("FAIL basic_busy: busy dropped, required high throughout"); end
    tick();
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL basic_sb: missing write, required addr %0d", e.addr);
      end else begin
        o = obs_q[rd_idx]; rd_idx++;
        if (o !== e) begin errors++; $display("FAIL basic_sb: wrote addr %0d data %0h required addr %0d data %0h", o.addr, o.data, e.addr, e.data); end
      end
    end
    checks++;
    if (n_writes - w0 != 2) begin errors++; $display("FAIL basic_nwr: %0d writes required 2", n_writes - w0); end
    checks++;
    if (mem[10] !== OP_W'(45) || mem[11] !== OP_W'(0)) begin
      errors++; $display("FAIL basic_mem: mem[10]=%0h mem[11]=%0h required 2d and 0", mem[10], mem[11]);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_idle: cmd_ready=%0b required 1", bus.cmd_ready); end
  endtask

  task automatic test_wrap();
    int cyc, sc; bit ball, gd, ge; wr_t e, o;
    logic [OP_W-1:0] ones, onesm1;
    ones = '1; onesm1 = ones - OP_W'(1);
    load(6'd0, ones);
    load(6'd1, ones);
    mul_delay = 3;
    issue(6'd0, 6'd1, 6'd63, 1'b1, 1'b0);
    wait_end(cyc, sc, ball, gd, ge);
    tick();
    checks++;
    if (!gd) begin errors++; $display("FAIL wrap_done: done=%0b required 1", gd); end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL wrap_sb: missing write, required addr %0d", e.addr);
      end else begin
        o = obs_q[rd_idx]; rd_idx++;
        if (o !== e) begin errors++; $display("FAIL wrap_sb: wrote addr %0d data %0h required addr %0d data %0h", o.addr, o.data, e.addr, e.data); end
      end
    end
    checks++;
    if (mem[63] !== OP_W'(1) || mem[0] !== onesm1 || mem[1] !== ones) begin
      errors++; $display("FAIL wrap_mem: mem[63]=%0h mem[0]=%0h mem[1]=%0h required 1, 2^260-2, 2^260-1", mem[63], mem[0], mem[1]);
    end
  endtask

  task automatic test_stall();
    int cyc, w0, lo_cycles; bit gd, seen_wr, dropped, unstable;
    logic [OP_W-1:0] lo_data; wr_t e, o;
    load(6'd3, OP_W'(5));
    load(6'd7, OP_W'(9));
    mul_delay = 4; stall_cfg = 5; w0 = n_writes;
    issue(6'd3, 6'd7, 6'd20, 1'b1, 1'b0);
    cyc = 1; gd = 0; seen_wr = 0; dropped = 0; unstable = 0; lo_cycles = 0; lo_data = '0;
    for (int i = 0; i < 300; i++) begin
      if (bus.done) begin gd = 1'b1; break; end
      if (bus.op_write) begin
        if (bus.op_waddr == 6'd20) begin
          if (lo_cycles == 0) lo_data = bus.op_wdata;
          else if (bus.op_wdata !== lo_data) unstable = 1'b1;
          lo_cycles++;
        end
        seen_wr = 1'b1;
      end else if (seen_wr) dropped = 1'b1;
      tick();
      cyc++;
    end
    checks++;
    if (!gd || cyc != 17) begin errors++; $display("FAIL stall_latency: done=%0b after %0d cycles required done=1 after 17", gd, cyc); end
    checks++;
    if (lo_cycles != 7 || unstable) begin errors++; $display("FAIL stall_hold: low word held %0d cycles unstable=%0b required 7 cycles stable", lo_cycles, unstable); end
    checks++;
    if (dropped) begin errors++; $display("FAIL stall_wr_gap: op_write dropped between words, required continuous"); end
    tick();
    stall_cfg = 0;
    checks++;
    if (n_writes - w0 != 2) begin errors++; $display("FAIL stall_nwr: %0d writes required 2", n_writes - w0); end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL stall_sb: missing write, required addr %0d", e.addr);
      end else begin
        o = obs_q[rd_idx]; rd_idx++;
        if (o !== e) begin errors++; $display("FAIL stall_sb: wrote addr %0d data %0h required addr %0d data %0h", o.addr, o.data, e.addr, e.data); end
      end
    end
  endtask

  task automatic test_timeout();
    int cyc, sc, wq0, d0; bit ball, gd, ge;
    mul_delay = 0; wq0 = n_wreq; d0 = n_done;
    issue(6'd3, 6'd7, 6'd40, 1'b0, 1'b0);
    wait_end(cyc, sc, ball, gd, ge);
    checks++;
    if (!ge || gd || sc < 0 || cyc - sc != 17) begin
      errors++; $display("FAIL timeout_err: err=%0b done=%0b after %0d cycles from mul_start required err after 17", ge, gd, cyc - sc);
    end
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL timeout_idle: cmd_ready=%0b err=%0b required 1,0", bus.cmd_ready, bus.err); end
    checks++;
    if (n_wreq != wq0 || n_done != d0) begin errors++; $display("FAIL timeout_nowr: op_write cycles %0d done %0d required 0,0", n_wreq - wq0, n_done - d0); end
  endtask

  task automatic test_reset_mid();
    int guard, w0, wq0, d0, e0, md0; logic [OP_W-1:0] zero;
    zero = '0;
    mul_delay = 6; w0 = n_writes; wq0 = n_wreq; d0 = n_done; e0 = n_err; md0 = n_muldone;
    issue(6'd3, 6'd7, 6'd50, 1'b0, 1'b0);
    guard = 0;
    while (!bus.mul_start && guard < 20) begin tick(); guard++; end
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.err, bus.op_read, bus.op_write, bus.mul_start} !== 7'b1000000) begin
      errors++;
      $display("FAIL rstmid_ctrl: {rdy,busy,done,err,rd,wr,start}=%b required 1000000",
               {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.op_read, bus.op_write, bus.mul_start});
    end
    checks++;
    if (bus.mul_a !== zero || bus.mul_b !== zero) begin errors++; $display("FAIL rstmid_ops: mul_a=%0h mul_b=%0h required 0", bus.mul_a, bus.mul_b); end
    repeat (10) tick();
    checks++;
    if (n_muldone - md0 != 1) begin errors++; $display("FAIL rstmid_late: late mul_done pulses %0d required 1", n_muldone - md0); end
    checks++;
    if (n_writes != w0 || n_wreq != wq0 || n_done != d0 || n_err != e0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet: writes %0d wreq %0d done %0d err %0d busy %0b required all 0",
                         n_writes - w0, n_wreq - wq0, n_done - d0, n_err - e0, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int a0, d0, e0, w0, guard; bit gd; wr_t e, o;
    mul_delay = 4; a0 = n_acc; d0 = n_done; e0 = n_err;
    issue(6'd7, 6'd7, 6'd30, 1'b1, 1'b1);
    gd = 0;
    for (guard = 0; guard < 100; guard++) begin
      if (bus.done) begin gd = 1'b1; break; end
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (!gd || n_acc - a0 != 1) begin errors++; $display("FAIL b2b_accept: done=%0b accepts %0d required 1 and 1", gd, n_acc - a0); end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL b2b_sb: missing write, required addr %0d", e.addr);
      end else begin
        o = obs_q[rd_idx]; rd_idx++;
        if (o !== e) begin errors++; $display("FAIL b2b_sb: wrote addr %0d data %0h required addr %0d data %0h", o.addr, o.data, e.addr, e.data); end
      end
    end
    w0 = n_writes; d0 = n_done;
    mul_done_pulse = 1'b1;
    tick();
    mul_done_pulse = 1'b0;
    repeat (6) tick();
    checks++;
    if (n_done != d0 || n_err != e0 || n_writes != w0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_muldone: done %0d err %0d writes %0d busy %0b required 0,0,0,0",
                         n_done - d0, n_err - e0, n_writes - w0, bus.busy);
    end
  endtask

  task automatic test_bus_exclusive();
    checks++;
    if (n_overlap != 0) begin errors++; $display("FAIL rd_wr_overlap: %0d cycles required 0", n_overlap); end
    checks++;
    if (exp_q.size() != 0 || rd_idx != obs_q.size()) begin
      errors++; $display("FAIL sb_leftover: expected %0d observed-unmatched %0d required 0,0", exp_q.size(), obs_q.size() - rd_idx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_bus_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
